rst_seq: RTL and testbench

Parametrised reset sequencer. It holds every downstream reset (CPU pipeline stages, caches, BPU, AXI bridge) asserted after system reset, then releases the channels one by one in index order, with a programmable step between releases. It also supports a masked soft-reset request that re-runs the sequence for a chosen subset of channels without disturbing the rest. It sits at the top level between the board reset and the CPU core.

---
 rtl/rst_seq_pkg.sv | 15 +
 rtl/rst_seq_timer.sv | 38 +++
 rtl/rst_seq.sv | 161 ++++++++++++++++
 tb/tb_rst_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Larger of two unsigned values; used to size the shared step timer.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable down-counter with a zero flag. It parks at zero and never wraps.
module rst_seq_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: a load wins, otherwise step down until zero is reached.
  always_comb begin
    // NOTE: the default assignment up front keeps every path assigned, so no latch is inferred.
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds all channel resets after system reset, then releases
// them in index order with a fixed slot per channel. A masked soft request
// from the idle state re-runs the sequence for a subset of channels only.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned       NUM_CH      = 10,
  parameter int unsigned       HOLD_CYC    = 4,
  parameter int unsigned       STEP_CYC    = 1,
  parameter logic [NUM_CH-1:0] ACTIVE_HIGH = {NUM_CH{1'b1}}
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              soft_req,
  input  logic [NUM_CH-1:0] soft_mask,
  output logic              soft_ack,
  output logic [NUM_CH-1:0] rst_out,
  output logic              busy,
  output logic              seq_done
);

  localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYC, STEP_CYC) + 1);
  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // The hold phase spends one cycle arming the timer, so it loads one less
  // than HOLD_CYC. Every slot but the last waits STEP_CYC cycles; the last
  // slot is a single cycle so DONE follows the final release directly.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CH - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                armed_q, armed_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [NUM_CH-1:0]   rst_q, rst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ack_q, ack_d;

  logic                tmr_load;
  logic [CNT_W-1:0]    tmr_val;
  logic                tmr_zero;

  rst_seq_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Deassert channel k if it takes part in the current sequence.
  function automatic logic [NUM_CH-1:0] release_ch(input logic [NUM_CH-1:0] cur,
                                                   input logic [NUM_CH-1:0] mask,
                                                   input logic [IDX_W-1:0]  k);
    logic [NUM_CH-1:0] res;
    res = cur;
    if (mask[k]) begin
      res[k] = ~ACTIVE_HIGH[k];
    end
    return res;
  endfunction

  // Next-state and registered-output logic for the hold/release/done walk.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    armed_d  = armed_q;
    mask_d   = mask_q;
    rst_d    = rst_q;
    busy_d   = busy_q;
    done_d   = done_q;
    ack_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;

    unique case (state_q)
      ST_HOLD: begin
        if (!armed_q) begin
          armed_d  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LOAD;
        end else if (tmr_zero) begin
          state_d  = ST_RELEASE;
          idx_d    = '0;
          rst_d    = release_ch(rst_q, mask_q, '0);
          tmr_load = 1'b1;
          tmr_val  = (LAST_IDX == '0) ? '0 : STEP_LOAD;
        end
      end

      ST_RELEASE: begin
        if (tmr_zero) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            rst_d    = release_ch(rst_q, mask_q, idx_d);
            tmr_load = 1'b1;
            tmr_val  = (idx_d == LAST_IDX) ? '0 : STEP_LOAD;
          end
        end
      end

      ST_DONE: begin
        if (soft_req) begin
          ack_d = 1'b1;
          if (soft_mask != '0) begin
            state_d  = ST_HOLD;
            idx_d    = '0;
            armed_d  = 1'b0;
            mask_d   = soft_mask;
            rst_d    = (rst_q & ~soft_mask) | (ACTIVE_HIGH & soft_mask);
            busy_d   = 1'b1;
            done_d   = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = '0;
          end
        end
      end

      default: begin
        state_d = ST_HOLD;
      end
    endcase
  end

  // State and output registers; reset restarts the full sequence.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_HOLD;
      idx_q   <= '0;
      armed_q <= 1'b0;
      mask_q  <= '1;
      rst_q   <= ACTIVE_HIGH;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      armed_q <= armed_d;
      mask_q  <= mask_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  assign rst_out  = rst_q;
  assign busy     = busy_q;
  assign seq_done = done_q;
  assign soft_ack = ack_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: a 4-channel instance (hold 3, step 2, mixed
// polarity) and a 1-channel active-low corner instance sharing one clock.
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       rstn;
  logic       soft_req;
  logic [3:0] soft_mask;
  logic       soft_ack;
  logic [3:0] rst_out;
  logic       busy;
  logic       seq_done;

  logic       rstn_c;
  logic       req_c;
  logic [0:0] mask_c;
  logic       ack_c;
  logic [0:0] rst_c;
  logic       busy_c;
  logic       done_c;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  rst_seq #(
    .NUM_CH      (4),
    .HOLD_CYC    (3),
    .STEP_CYC    (2),
    .ACTIVE_HIGH (4'b0011)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .soft_req  (soft_req),
    .soft_mask (soft_mask),
    .soft_ack  (soft_ack),
    .rst_out   (rst_out),
    .busy      (busy),
    .seq_done  (seq_done)
  );

  rst_seq #(
    .NUM_CH      (1),
    .HOLD_CYC    (1),
    .STEP_CYC    (1),
    .ACTIVE_HIGH (1'b0)
  ) dut_c (
    .clk       (clk),
    .rstn      (rstn_c),
    .soft_req  (req_c),
    .soft_mask (mask_c),
    .soft_ack  (ack_c),
    .rst_out   (rst_c),
    .busy      (busy_c),
    .seq_done  (done_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s c%0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Hand-derived power-up timeline for hold 3, step 2, polarity 0011.
  function automatic logic [3:0] pu_rst(input int c);
    if (c < 4)  return 4'b0011;
    if (c < 6)  return 4'b0010;
    if (c < 8)  return 4'b0000;
    if (c < 10) return 4'b0100;
    return 4'b1100;
  endfunction

  task automatic check_pu(input string tag);
    check({tag, "_rst"},  32'(rst_out),  32'(pu_rst(cyc)));
    check({tag, "_busy"}, 32'(busy),     32'(cyc < 11));
    check({tag, "_done"}, 32'(seq_done), 32'(cyc >= 11));
    check({tag, "_ack"},  32'(soft_ack), 32'd0);
  endtask

  initial begin
    rstn      = 1'b0;
    rstn_c    = 1'b0;
    soft_req  = 1'b0;
    soft_mask = 4'b0000;
    req_c     = 1'b0;
    mask_c    = 1'b0;

    // Reset held for five cycles: everything asserted, busy, not done.
    repeat (5) tick();
    check("rst_rst",   32'(rst_out),  32'h3);
    check("rst_busy",  32'(busy),     32'd1);
    check("rst_done",  32'(seq_done), 32'd0);
    check("rst_ack",   32'(soft_ack), 32'd0);
    check("rstc_rst",  32'(rst_c),    32'd0);
    check("rstc_busy", 32'(busy_c),   32'd1);

    // Power-up of both instances; this cycle is cycle 0.
    rstn   = 1'b1;
    rstn_c = 1'b1;
    cyc    = 0;
    check_pu("pu");
    check("pc_rst",  32'(rst_c),  32'd0);
    check("pc_done", 32'(done_c), 32'd0);
    while (cyc < 11) begin
      tick();
      check_pu("pu");
      check("pc_rst",  32'(rst_c),  32'(cyc >= 2));
      check("pc_busy", 32'(busy_c), 32'(cyc < 3));
      check("pc_done", 32'(done_c), 32'(cyc >= 3));
    end

    // Zero-mask request in DONE: ack only, nothing else moves.
    soft_req  = 1'b1;
    soft_mask = 4'b0000;
    tick();
    check("zm_ack",  32'(soft_ack), 32'd1);
    check("zm_rst",  32'(rst_out),  32'hc);
    check("zm_busy", 32'(busy),     32'd0);
    check("zm_done", 32'(seq_done), 32'd1);
    soft_req = 1'b0;
    tick();
    check("zm_ack2",  32'(soft_ack), 32'd0);
    check("zm_done2", 32'(seq_done), 32'd1);

    // Soft reset of channels 0 and 2; cycle t is this one.
    soft_req  = 1'b1;
    soft_mask = 4'b0101;
    cyc       = 0;
    tick();
    soft_req = 1'b0;
    check("sr_ack",  32'(soft_ack), 32'd1);
    check("sr_rst",  32'(rst_out),  32'h9);
    check("sr_busy", 32'(busy),     32'd1);
    check("sr_done", 32'(seq_done), 32'd0);
    while (cyc < 12) begin
      tick();
      check("sr_rst",  32'(rst_out),
            (cyc < 5) ? 32'h9 : (cyc < 9) ? 32'h8 : 32'hc);
      check("sr_ack",  32'(soft_ack), 32'd0);
      check("sr_busy", 32'(busy),     32'(cyc < 12));
      check("sr_done", 32'(seq_done), 32'(cyc >= 12));
    end

    // Reset asserted at cycle 7 of a fresh power-up sequence.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    cyc  = 0;
    while (cyc < 7) tick();
    check_pu("mid");
    rstn = 1'b0;
    tick();
    check("mid_rst",  32'(rst_out),  32'h3);
    check("mid_done", 32'(seq_done), 32'd0);
    check("mid_busy", 32'(busy),     32'd1);
    rstn = 1'b1;
    cyc  = 0;
    check_pu("rep");
    while (cyc < 11) begin
      tick();
      check_pu("rep");
    end

    // Request raised at cycle 5 of a power-up and held until acknowledged.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    cyc  = 0;
    while (cyc < 5) tick();
    soft_req  = 1'b1;
    soft_mask = 4'b1000;
    while (cyc < 11) begin
      tick();
      check_pu("busy");
    end
    tick();
    soft_req = 1'b0;
    check("hq_ack",  32'(soft_ack), 32'd1);
    check("hq_rst",  32'(rst_out),  32'h4);
    check("hq_busy", 32'(busy),     32'd1);
    check("hq_done", 32'(seq_done), 32'd0);
    while (cyc < 23) begin
      tick();
      check("hq_rst",  32'(rst_out),  (cyc < 22) ? 32'h4 : 32'hc);
      check("hq_ack",  32'(soft_ack), 32'd0);
      check("hq_done", 32'(seq_done), 32'(cyc >= 23));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
